uart_baud_driver: RTL and testbench

//   Bench-side UART transmitter: serializes bytes as 8N1 frames onto the SoC UART_RX line.
//   It is the stimulus partner of uart_baud_monitor and uses the same baud derivation,
//   so driver->monitor loopback matches bit for bit.

---
 rtl/uart_baud_driver.sv | 244 ++++++++++++++++++++++++
 tb/tb_uart_baud_driver.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_baud_driver.sv
// -----------------------------------------------------------------------------
// uart_baud_driver
//
// Bench-side UART transmitter. Bytes queued through a small FIFO are sent as
// 8N1 frames (start bit, 8 data bits LSB first, one stop bit) on uart_tx.
// Frames go out back to back while the FIFO holds data. The bit period is
// derived exactly as in uart_baud_monitor, so driver->monitor loopback lines
// up bit for bit.
//
// Parameters
//   CLK_FREQ_MHZ  system clock frequency in MHz
//   BAUD_RATE     line rate in bit/s
//   OVERSAMPLE    divider ticks per bit
//   FIFO_DEPTH    queued bytes (power of 2, >= 2)
//
// Ports
//   clk         in   system clock, rising edge
//   reset       in   synchronous, active-low reset
//   in_valid    in   byte offered this cycle
//   in_byte     in   byte to send (sampled only on a push)
//   in_ready    out  FIFO not full; push = in_valid & in_ready
//   uart_tx     out  serial line, idle high
//   busy        out  frame in progress or FIFO non-empty
//   frame_done  out  one-cycle pulse during the last clock of each stop bit
//   fifo_count  out  bytes queued, excluding the byte being shifted
// -----------------------------------------------------------------------------
module uart_baud_driver #(
  parameter int CLK_FREQ_MHZ = 27,
  parameter int BAUD_RATE    = 115200,
  parameter int OVERSAMPLE   = 16,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [7:0]                    in_byte,
  output logic                          in_ready,
  output logic                          uart_tx,
  output logic                          busy,
  output logic                          frame_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  // Divider derivation shared with the monitor; floor, but never below 1.
  localparam int TICK_RAW = (CLK_FREQ_MHZ * 1000000) / (BAUD_RATE * OVERSAMPLE);
  localparam int TICK_DIV = (TICK_RAW < 1) ? 1 : TICK_RAW;

  localparam int DIV_W = $clog2(TICK_DIV + 1);
  localparam int TCK_W = $clog2(OVERSAMPLE + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [TCK_W-1:0] TCK_LAST = TCK_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  // Control state
  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [TCK_W-1:0] tick_q, tick_d;
  logic [2:0]       bit_q, bit_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Datapath state
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       mem_q [FIFO_DEPTH];

  logic             push;
  logic             pop;
  logic             bit_end;
  logic             fifo_nonempty;
  logic [7:0]       head_byte;

  // in_ready depends on registered state only, so a pop in the same cycle
  // never lets a push into a full FIFO.
  assign in_ready      = (cnt_q != FULL_CNT);
  assign push          = in_valid && in_ready;
  assign fifo_nonempty = (cnt_q != '0);
  assign head_byte     = mem_q[rd_ptr_q];

  // Last clock of the current bit period: both counters at their final value.
  assign bit_end = (div_q == DIV_LAST) && (tick_q == TCK_LAST);

  assign uart_tx    = tx_q;
  assign frame_done = done_q;
  assign fifo_count = cnt_q;
  assign busy       = (state_q != IDLE) || fifo_nonempty;

  // ---------------------------------------------------------------------------
  // Next-state logic: bit timing and frame sequencing
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    done_d  = 1'b0;

    // Counters run only inside a frame. At bit_end both wrap to zero, which is
    // exactly the state a new bit (or a back-to-back start bit) needs.
    if (state_q != IDLE) begin
      if (div_q == DIV_LAST) begin
        div_d  = '0;
        tick_d = (tick_q == TCK_LAST) ? '0 : tick_q + TCK_W'(1);
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        div_d  = '0;
        tick_d = '0;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = head_byte;
          tx_d    = 1'b0;
          state_d = START;
        end
      end

      START: begin
        if (bit_end) begin
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          bit_d   = 3'd0;
          state_d = DATA;
        end
      end

      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
            bit_d   = bit_q + 3'd1;
          end
        end
      end

      STOP: begin
        if (bit_end) begin
          if (fifo_nonempty) begin
            // Chain straight into the next start bit, no idle gap.
            pop     = 1'b1;
            shift_d = head_byte;
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase

    // frame_done is registered, so it is raised on the edge that enters the
    // final clock of the stop bit, i.e. when the next counter values are final.
    done_d = (state_d == STOP) && (div_d == DIV_LAST) && (tick_d == TCK_LAST);
  end

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= IDLE;
      div_q    <= '0;
      tick_q   <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      div_q    <= div_d;
      tick_q   <= tick_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Data registers: contents are only meaningful behind valid control state
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (push) begin
      mem_q[wr_ptr_q] <= in_byte;
    end
  end

endmodule

// File: tb/tb_uart_baud_driver.sv
module tb_uart_baud_driver;

  localparam int BIT_CYC = 224;   // 14 * 16 at default parameters
  localparam int HALF    = 112;
  localparam int FRAME   = 2240;  // 10 bit periods

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       in_ready;
  logic       uart_tx;
  logic       busy;
  logic       frame_done;
  logic [4:0] fifo_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int rx_q[$];      // {stop_bit, data} per received frame
  int start_q[$];   // edge index of each start bit
  int fd_q[$];      // edge index of each frame_done pulse
  int fall_cnt = 0;
  logic prev_edge_tx = 1'b1;

  uart_baud_driver #(
    .CLK_FREQ_MHZ(27),
    .BAUD_RATE(115200),
    .OVERSAMPLE(16),
    .FIFO_DEPTH(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_byte(in_byte),
    .in_ready(in_ready),
    .uart_tx(uart_tx),
    .busy(busy),
    .frame_done(frame_done),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  // Edge index: after rising edge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  // Line observer: frame_done pulses and start-bit falling edges.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (frame_done === 1'b1) fd_q.push_back(cyc);
      if (prev_edge_tx === 1'b1 && uart_tx === 1'b0) fall_cnt++;
      prev_edge_tx = uart_tx;
    end
  end

  // Loopback receiver: samples mid-bit after a detected falling edge.
  initial begin : monitor
    logic       prev;
    logic [7:0] b;
    logic       stop_bit;
    int         st;
    prev = 1'b1;
    b = 8'h00;
    forever begin
      @(posedge clk);
      #2;
      if (prev === 1'b1 && uart_tx === 1'b0) begin
        st = cyc;
        repeat (HALF) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (BIT_CYC) @(posedge clk);
          #2;
          b[i] = uart_tx;
        end
        repeat (BIT_CYC) @(posedge clk);
        #2;
        stop_bit = uart_tx;
        rx_q.push_back(int'({23'd0, stop_bit, b}));
        start_q.push_back(st);
        prev = uart_tx;
      end else begin
        prev = uart_tx;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int target);
    if (cyc > target) check("schedule", 32'(cyc), 32'(target));
    while (cyc < target) tick();
  endtask

  task automatic clear_logs();
    rx_q.delete();
    start_q.delete();
    fd_q.delete();
  endtask

  initial begin
    int n;
    int s;
    int acc;
    int fc;
    int fdn;
    logic [7:0] pat;

    // ---- 1: reset held three cycles, then released
    reset = 1'b0;
    repeat (3) tick();
    check("rst_tx",    32'(uart_tx),    32'd1);
    check("rst_ready", 32'(in_ready),   32'd1);
    check("rst_busy",  32'(busy),       32'd0);
    check("rst_done",  32'(frame_done), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    reset = 1'b1;
    tick();
    check("rel_tx",    32'(uart_tx),    32'd1);
    check("rel_ready", 32'(in_ready),   32'd1);
    check("rel_busy",  32'(busy),       32'd0);
    check("rel_count", 32'(fifo_count), 32'd0);
    clear_logs();

    // ---- 2: single byte 0x55
    in_valid = 1'b1;
    in_byte  = 8'h55;
    tick();
    n = cyc;
    in_valid = 1'b0;
    in_byte  = 8'hAA;   // must be ignored
    check("t2_count_push", 32'(fifo_count), 32'd1);
    check("t2_tx_pre",     32'(uart_tx),    32'd1);
    check("t2_busy",       32'(busy),       32'd1);
    tick();
    check("t2_start_fall", 32'(uart_tx),    32'd0);
    check("t2_count_pop",  32'(fifo_count), 32'd0);
    pat = 8'b0101_0101;   // expected line levels bit7..bit0 = 0,1,0,1,0,1,0,1
    for (int k = 1; k <= 8; k++) begin
      wait_until(n + 1 + BIT_CYC * k + HALF);
      check("t2_data_bit", 32'(uart_tx), 32'(pat[k-1]));
    end
    wait_until(n + 1 + BIT_CYC * 9 + HALF);
    check("t2_stop_bit", 32'(uart_tx), 32'd1);
    wait_until(n + FRAME - 1);
    check("t2_done_early", 32'(frame_done), 32'd0);
    tick();
    check("t2_done_pulse", 32'(frame_done), 32'd1);
    tick();
    check("t2_done_clear", 32'(frame_done), 32'd0);
    check("t2_idle_busy",  32'(busy),       32'd0);
    check("t2_idle_tx",    32'(uart_tx),    32'd1);
    check("t2_rx_count",   32'(rx_q.size()), 32'd1);
    if (rx_q.size() > 0) begin
      check("t2_rx_byte",  32'(rx_q[0]),    32'h155);
      check("t2_start_at", 32'(start_q[0]), 32'(n + 1));
    end
    check("t2_fd_count", 32'(fd_q.size()), 32'd1);
    if (fd_q.size() > 0) check("t2_fd_at", 32'(fd_q[0]), 32'(n + FRAME));
    clear_logs();

    // ---- 3: 0x00 then 0xFF back to back
    in_valid = 1'b1;
    in_byte  = 8'h00;
    tick();
    n = cyc;
    in_byte  = 8'hFF;
    tick();
    in_valid = 1'b0;
    check("t3_count_pushpop", 32'(fifo_count), 32'd1);
    wait_until(n + 1 + 2 * FRAME + 5);
    check("t3_idle_busy", 32'(busy), 32'd0);
    check("t3_rx_count",  32'(rx_q.size()), 32'd2);
    if (rx_q.size() == 2) begin
      check("t3_rx0",     32'(rx_q[0]), 32'h100);
      check("t3_rx1",     32'(rx_q[1]), 32'h1FF);
      check("t3_start0",  32'(start_q[0]), 32'(n + 1));
      check("t3_spacing", 32'(start_q[1] - start_q[0]), 32'(FRAME));
    end
    check("t3_fd_count", 32'(fd_q.size()), 32'd2);
    if (fd_q.size() == 2) check("t3_fd_spacing", 32'(fd_q[1] - fd_q[0]), 32'(FRAME));
    clear_logs();

    // ---- 4: 20 consecutive offers, 17 accepted
    acc = 0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1;
      in_byte  = 8'(8'h41 + i);
      if (in_ready === 1'b1) acc++;
      tick();
      if (i == 0) n = cyc;
      if (i >= 16) check("t4_ready_full", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    check("t4_accepted", 32'(acc), 32'd17);
    check("t4_count_full", 32'(fifo_count), 32'd16);

    // ---- 5: push attempted on the STOP->START pop edge while full
    s = n + 1;   // start edge of the 0x41 frame
    wait_until(s + FRAME - 1);
    check("t5_done_pulse",  32'(frame_done), 32'd1);
    check("t5_count_before", 32'(fifo_count), 32'd16);
    check("t5_ready_before", 32'(in_ready),   32'd0);
    in_valid = 1'b1;
    in_byte  = 8'hEE;
    tick();
    in_valid = 1'b0;
    check("t5_count_after", 32'(fifo_count), 32'd15);
    check("t5_start_next",  32'(uart_tx),    32'd0);
    check("t5_ready_after", 32'(in_ready),   32'd1);

    wait_until(s + 17 * FRAME + 5);
    check("t4_idle_busy", 32'(busy), 32'd0);
    check("t4_rx_count",  32'(rx_q.size()), 32'd17);
    if (rx_q.size() == 17) begin
      for (int j = 0; j < 17; j++) begin
        check("t4_rx_byte", 32'(rx_q[j]), 32'(32'h141 + j));
        if (j > 0) check("t4_start_spacing", 32'(start_q[j] - start_q[j-1]), 32'(FRAME));
      end
    end
    check("t4_fd_count", 32'(fd_q.size()), 32'd17);
    if (fd_q.size() == 17) begin
      for (int j = 1; j < 17; j++) begin
        check("t4_fd_spacing", 32'(fd_q[j] - fd_q[j-1]), 32'(FRAME));
      end
    end
    clear_logs();

    // ---- 6: reset during data bit 3, with one byte still queued
    in_valid = 1'b1;
    in_byte  = 8'hC3;   // bit3 = 0, so the line is low when reset hits
    tick();
    s = cyc + 1;
    in_byte  = 8'h3C;
    tick();
    in_valid = 1'b0;
    check("t6_count_queued", 32'(fifo_count), 32'd1);
    wait_until(s + 4 * BIT_CYC + 100);
    check("t6_bit3_low", 32'(uart_tx), 32'd0);
    reset = 1'b0;
    tick();
    check("t6_rst_tx",    32'(uart_tx),    32'd1);
    check("t6_rst_count", 32'(fifo_count), 32'd0);
    check("t6_rst_busy",  32'(busy),       32'd0);
    check("t6_rst_ready", 32'(in_ready),   32'd1);
    check("t6_rst_done",  32'(frame_done), 32'd0);
    reset = 1'b1;
    fc  = fall_cnt;
    fdn = fd_q.size();
    repeat (3000) tick();
    check("t6_no_start",  32'(fall_cnt),    32'(fc));
    check("t6_no_done",   32'(fd_q.size()), 32'(fdn));
    check("t6_idle_tx",   32'(uart_tx),     32'd1);
    check("t6_idle_busy", 32'(busy),        32'd0);
    clear_logs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
